// File: rtl/ula_cmd_sequencer.sv
// rtl/ula_cmd_sequencer.sv - queues ULA opcodes and sequences each through load, run and completion
module ula_cmd_sequencer #(
   parameter int         FIFO_DEPTH     = 4,
   parameter int         RST_CYCLES     = 2,
   parameter int         TIMEOUT_CYCLES = 1048575,
   parameter logic [3:0] IDLE_SEL       = 4'b0111
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [3:0]                  cmd_op,
   input  logic                        abort,
   input  logic                        clr_err,
   output logic [3:0]                  ula_seletor,
   output logic                        ula_reset_n,
   input  logic                        ula_done,
   output logic                        busy,
   output logic                        op_done,
   output logic [3:0]                  op_last,
   output logic                        err_opcode,
   output logic                        err_timeout,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0]                 op_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int LW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [PW:0]   FULL_LVL = FIFO_DEPTH[PW:0];
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0] RST_LAST = LW'(RST_CYCLES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [3:0]    cur_op_q, cur_op_d;
   logic [LW-1:0] ld_cnt_q, ld_cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          armed_q, armed_d;
   logic          started_q, started_d;
   logic [3:0]    sel_q, sel_d;
   logic          rst_n_q, rst_n_d;
   logic          op_done_q, op_done_d;
   logic [3:0]    op_last_q, op_last_d;
   logic [15:0]   op_count_q, op_count_d;
   logic          err_op_q, err_op_d;
   logic          err_tmo_q, err_tmo_d;
   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [3:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;

   logic full, accept, push, bad_op, pop, set_tmo;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
         4'b1000, 4'b1001, 4'b1010, 4'b1011: op_legal = 1'b1;
         default:                             op_legal = 1'b0;
      endcase
   endfunction

   assign full        = (count_q == FULL_LVL);
   assign cmd_ready   = started_q & ~full & ~abort;
   assign accept      = cmd_valid & cmd_ready;
   assign push        = accept & op_legal(cmd_op);
   assign bad_op      = accept & ~op_legal(cmd_op);
   assign busy        = (state_q != S_IDLE) || (count_q != '0);
   assign ula_seletor = sel_q;
   assign ula_reset_n = rst_n_q;
   assign op_done     = op_done_q;
   assign op_last     = op_last_q;
   assign op_count    = op_count_q;
   assign err_opcode  = err_op_q;
   assign err_timeout = err_tmo_q;
   assign fifo_level  = count_q;

   // Sequencer next state: pop in IDLE, hold ULA in reset during LOAD, watch done/timeout in RUN
   always_comb begin
      state_d  = state_q;
      cur_op_d = cur_op_q;
      ld_cnt_d = ld_cnt_q;
      tmo_d    = tmo_q;
      armed_d  = armed_q;
      pop      = 1'b0;
      set_tmo  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop      = 1'b1;
               cur_op_d = mem_q[rd_ptr_q];
               ld_cnt_d = '0;
               tmo_d    = '0;
               armed_d  = 1'b0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (ld_cnt_q == RST_LAST) state_d = S_RUN;
            else                      ld_cnt_d = ld_cnt_q + 1'b1;
         end
         S_RUN: begin
            tmo_d = tmo_q + 1'b1;
            if (!ula_done) armed_d = 1'b1;
            // a done that was high before arming is a leftover from the previous op
            if (armed_q && ula_done) begin
               state_d = S_DONE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_DRAIN;
               set_tmo = 1'b1;
            end
         end
         S_DONE, S_DRAIN: state_d = S_IDLE;
         default:         state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d  = S_DRAIN;
         cur_op_d = cur_op_q;
         pop      = 1'b0;
         set_tmo  = 1'b0;
      end
   end

   // Registered ULA drive, completion bookkeeping and sticky errors, all aligned to the next state
   always_comb begin
      sel_d      = IDLE_SEL;
      rst_n_d    = 1'b1;
      op_last_d  = op_last_q;
      op_count_d = op_count_q;
      started_d  = 1'b1;
      case (state_d)
         S_LOAD: begin
            sel_d   = cur_op_d;
            rst_n_d = 1'b0;
         end
         S_RUN:   sel_d   = cur_op_d;
         S_DRAIN: rst_n_d = 1'b0;
         default: ;
      endcase
      op_done_d = (state_d == S_DONE);
      if (state_d == S_DONE) begin
         op_last_d  = cur_op_q;
         op_count_d = op_count_q + 16'd1;
      end
      err_op_d  = bad_op  | (err_op_q  & ~clr_err);
      err_tmo_d = set_tmo | (err_tmo_q & ~clr_err);
   end

   // Command queue: abort flushes everything; a full queue refuses pushes even when popping
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = cmd_op;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cur_op_q   <= '0;
         ld_cnt_q   <= '0;
         tmo_q      <= '0;
         armed_q    <= 1'b0;
         started_q  <= 1'b0;
         sel_q      <= IDLE_SEL;
         rst_n_q    <= 1'b0;
         op_done_q  <= 1'b0;
         op_last_q  <= '0;
         op_count_q <= '0;
         err_op_q   <= 1'b0;
         err_tmo_q  <= 1'b0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cur_op_q   <= cur_op_d;
         ld_cnt_q   <= ld_cnt_d;
         tmo_q      <= tmo_d;
         armed_q    <= armed_d;
         started_q  <= started_d;
         sel_q      <= sel_d;
         rst_n_q    <= rst_n_d;
         op_done_q  <= op_done_d;
         op_last_q  <= op_last_d;
         op_count_q <= op_count_d;
         err_op_q   <= err_op_d;
         err_tmo_q  <= err_tmo_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_ula_cmd_sequencer.sv
// tb/tb_ula_cmd_sequencer.sv - randomized self-checking bench for ula_cmd_sequencer
module tb_ula_cmd_sequencer;

   localparam int         FIFO_DEPTH = 4;
   localparam int         RST_CYCLES = 2;
   localparam int         TMO        = 50;
   localparam logic [3:0] IDLE_SEL   = 4'b0111;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic        abort = 1'b0;
   logic        clr_err = 1'b0;
   logic [3:0]  ula_seletor;
   logic        ula_reset_n;
   logic        ula_done = 1'b0;
   logic        busy;
   logic        op_done;
   logic [3:0]  op_last;
   logic        err_opcode;
   logic        err_timeout;
   logic [2:0]  fifo_level;
   logic [15:0] op_count;

   ula_cmd_sequencer #(
      .FIFO_DEPTH(FIFO_DEPTH), .RST_CYCLES(RST_CYCLES),
      .TIMEOUT_CYCLES(TMO), .IDLE_SEL(IDLE_SEL)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .abort(abort), .clr_err(clr_err), .ula_seletor(ula_seletor),
      .ula_reset_n(ula_reset_n), .ula_done(ula_done), .busy(busy), .op_done(op_done),
      .op_last(op_last), .err_opcode(err_opcode), .err_timeout(err_timeout),
      .fifo_level(fifo_level), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // d = RUN cycle index at which the ULA raises done (0 = never); stale = done high on RUN entry
   typedef struct { logic [3:0] op; int d; bit stale; } op_t;

   op_t exp_q[$];
   op_t cur;
   int  n_checks = 0;
   int  n_errors = 0;
   int  model_count = 0;
   bit  model_err_op = 0;
   bit  model_err_tmo = 0;
   int  phase = 0;
   int  lc = 0;
   int  rc = 0;
   bit  abort_pend = 0;
   bit  pulse_chk = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input logic [3:0] op);
      return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
   endfunction

   // ULA model plus per-op scoreboard, evaluated mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            phase = 0; ula_done = 1'b0; abort_pend = 0; pulse_chk = 0;
         end else begin
            if (pulse_chk) begin
               chk("op_done_one_cycle", op_done, 1'b0);
               pulse_chk = 0;
            end
            if (!ula_reset_n && ula_seletor != IDLE_SEL) begin
               if (phase != 1) begin
                  phase = 1; lc = 0;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_load", 1, 0);
                     cur.op = ula_seletor; cur.d = 1; cur.stale = 0;
                  end else begin
                     cur = exp_q.pop_front();
                     chk("load_seletor", ula_seletor, cur.op);
                  end
               end
               lc++;
               ula_done = cur.stale;
            end else if (ula_reset_n && ula_seletor != IDLE_SEL) begin
               if (phase == 1) begin
                  chk("load_len", lc, RST_CYCLES);
                  phase = 2; rc = 0;
               end
               ula_done = (cur.stale && rc < 3) || (cur.d > 0 && rc >= cur.d);
               rc++;
            end else begin
               ula_done = 1'b0;
               if (phase == 2) begin
                  if (abort_pend) begin
                     chk("abort_drain_rstn", ula_reset_n, 1'b0);
                     chk("abort_no_done", op_done, 1'b0);
                     chk("abort_count", op_count, model_count);
                     chk("abort_level", fifo_level, 0);
                     abort_pend = 0;
                  end else if (cur.d > 0 && cur.d < TMO) begin
                     chk("run_len", rc, cur.d + 1);
                     chk("op_done_pulse", op_done, 1'b1);
                     chk("op_last", op_last, cur.op);
                     chk("op_count", op_count, model_count + 1);
                     model_count++;
                     pulse_chk = 1;
                  end else begin
                     chk("tmo_run_len", rc, TMO);
                     chk("tmo_drain_rstn", ula_reset_n, 1'b0);
                     chk("tmo_no_done", op_done, 1'b0);
                     chk("tmo_err", err_timeout, 1'b1);
                     model_err_tmo = 1;
                  end
               end
               phase = 0;
            end
         end
      end
   end

   task automatic push(input logic [3:0] op, input int d, input bit stale);
      int n;
      op_t e;
      cmd_valid = 1'b1; cmd_op = op; n = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         chk("ready_low_only_when_full", fifo_level, FIFO_DEPTH);
         n++;
         if (n > 2000) begin
            chk("push_stuck", 0, 1);
            cmd_valid = 1'b0;
            return;
         end
      end
      if (is_legal(op)) begin
         e.op = op; e.d = d; e.stale = stale;
         exp_q.push_back(e);
      end else begin
         model_err_op = 1;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!(busy == 1'b0 && phase == 0) && n < 3000);
      if (n >= 3000) chk({tag, "_idle_timeout"}, 0, 1);
      chk({tag, "_count"}, op_count, model_count);
      chk({tag, "_err_op"}, err_opcode, model_err_op);
      chk({tag, "_err_tmo"}, err_timeout, model_err_tmo);
      chk({tag, "_level"}, fifo_level, 0);
      chk({tag, "_all_ops_ran"}, exp_q.size(), 0);
   endtask

   task automatic clear_errs();
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      model_err_op = 0; model_err_tmo = 0;
      chk("clr_err_op", err_opcode, 1'b0);
      chk("clr_err_tmo", err_timeout, 1'b0);
   endtask

   task automatic wait_running(input int min_rc);
      int n = 0;
      do begin
         @(posedge clk); n++;
      end while (!(phase == 2 && rc >= min_rc) && n < 500);
      if (n >= 500) chk("wait_running_timeout", 0, 1);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel, d, gap;
      logic [3:0] op;
      bit st;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_seletor", ula_seletor, IDLE_SEL);
      chk("rst_rstn", ula_reset_n, 1'b0);
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_op_done", op_done, 1'b0);
      chk("rst_op_last", op_last, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_errs", {err_opcode, err_timeout}, 0);
      reset = 1'b1;
      #1 chk("ready_before_first_edge", cmd_ready, 1'b0);
      @(posedge clk); #1;
      chk("rstn_after_release", ula_reset_n, 1'b1);
      chk("ready_after_release", cmd_ready, 1'b1);

      // single op
      push(4'b0001, 10, 0);
      wait_idle("t1");

      // fill queue past full while first op is long
      push(4'b0000, 30, 0);
      push(4'b1000, 5, 0);
      push(4'b0011, 8, 0);
      push(4'b1011, 3, 0);
      push(4'b0001, 6, 0);
      push(4'b1001, 4, 0);
      wait_idle("t2");

      // illegal opcode
      push(4'b0101, 1, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("t3_busy", busy, 1'b0);
      chk("t3_level", fifo_level, 0);
      chk("t3_err_op", err_opcode, 1'b1);
      clear_errs();

      // timeout, done on the last allowed cycle, then a normal op
      push(4'b0010, 0, 0);
      push(4'b0100, TMO - 1, 0);
      push(4'b1010, 5, 0);
      wait_idle("t4");
      clear_errs();

      // stale done on RUN entry
      push(4'b0011, 8, 1);
      wait_idle("t5");

      // abort mid-run with two queued ops and a same-cycle offer
      push(4'b1000, 0, 0);
      push(4'b0001, 5, 0);
      push(4'b0010, 5, 0);
      wait_running(3);
      abort = 1'b1; cmd_valid = 1'b1; cmd_op = 4'b0001;
      exp_q.delete();
      abort_pend = 1;
      #1 chk("ready_during_abort", cmd_ready, 1'b0);
      @(posedge clk); #1;
      abort = 1'b0; cmd_valid = 1'b0;
      wait_idle("t6");

      // abort while idle and empty still costs one DRAIN cycle
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("idle_abort_drain", ula_reset_n, 1'b0);
      @(posedge clk); #1;
      chk("idle_abort_back", ula_reset_n, 1'b1);
      chk("idle_abort_busy", busy, 1'b0);

      // randomized ops, delays and gaps
      for (int i = 0; i < 30; i++) begin
         op  = 4'($urandom_range(0, 15));
         sel = $urandom_range(0, 5);
         case (sel)
            0:       d = 0;
            1:       d = TMO - 1;
            2:       d = TMO;
            default: d = $urandom_range(1, 20);
         endcase
         st = (d == 0 || d >= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         push(op, d, st);
         gap = $urandom_range(0, 3);
         repeat (gap) begin @(posedge clk); #1; end
         if (i % 6 == 5) begin
            wait_idle("rnd");
            clear_errs();
         end
      end
      wait_idle("rnd_end");

      // asynchronous reset in the middle of an op
      push(4'b1001, 0, 0);
      push(4'b0011, 5, 0);
      wait_running(2);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_seletor", ula_seletor, IDLE_SEL);
      chk("async_rst_rstn", ula_reset_n, 1'b0);
      chk("async_rst_level", fifo_level, 0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_count", op_count, 0);
      exp_q.delete();
      model_count = 0; model_err_op = 0; model_err_tmo = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      push(4'b0100, 7, 0);
      wait_idle("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
